conv_window_mac: RTL
====================

# conv_window_mac

Sequential 5x5 convolution engine that sits downstream of the CNN line-buffer/window generator. It accepts one packed 5x5 window of signed 9-bit pixels per handshake and multiplies it element-wise against a 25-entry signed weight register file. The products are summed through a single time-multiplexed multiply-accumulator, one tap per cycle. It returns one full-precision signed sum per window over a valid/ready output handshake.

## Interface
- `DW`, 9, pixel and weight width (signed two's complement)
- `K`, 5, window edge; window holds K*K = 25 taps
- `ACC_W`, 23, accumulator/result width, equal to 2*DW + ceil(log2(K*K))
- `clk` input 1: the single clock; all logic on rising edge
- `rst` input 1: reset; synchronous and active-high
- `win_valid` input 1: window present on `win_data`
- `win_ready` output 1: engine can accept a window
- `win_data` input K*K*DW: tap (r,c) is at bits [(r*K+c)*DW +: DW]; r=0 is the top row, c=0 the left column
- `wgt_we` input 1: weight write strobe
- `wgt_addr` input 5: weight index r*K+c
- `wgt_data` input DW: signed weight value
- `busy` output 1: high when the state is not IDLE
- `res_valid` output 1: result present
- `res_ready` input 1: consumer takes the result
- `res_data` output ACC_W: signed convolution sum

## Operation
- FSM states:
  - IDLE: `win_ready`=1. When `win_valid` is high, the window is latched into a local register, acc<=0, idx<=0, and the state goes to RUN.
  - RUN: each cycle acc <= acc + win[idx]*wgt[idx], then idx++. The sign-extended 2*DW product is added into ACC_W bits. On the cycle where idx==K*K-1, the final sum is loaded into the `res_data` register and the state goes to DONE.
  - DONE: `res_valid`=1 and `res_data` is held. When `res_ready` is high, the state goes to IDLE.
- Weights:
  - `wgt_we` is honoured only in IDLE. It is ignored in RUN and DONE, so weights stay constant for an entire window.
  - `wgt_addr` values 25..31 are ignored.
  - A weight write in IDLE in the same cycle as a window acceptance takes effect and is used for that window, since the first product is formed the next cycle.
- Arithmetic:
  - Full signed precision; no rounding, saturation or truncation.
  - Worst case is 25*(-256)*(-256) = 1638400, which fits in 23 bits.
- The local copy of the window lets the upstream generator advance as soon as the handshake completes.

## Timing
- Reset values: state IDLE, `win_ready`=0 while `rst` is high and 1 from the first cycle after release. `res_valid`=0, `res_data`=0, `busy`=0, acc=0, idx=0, all 25 weights 0.
- Latency: window accepted at edge T. The 25 accumulate edges are T+1..T+25. `res_valid` rises after edge T+25, i.e. 25 cycles after acceptance.
- Minimum window period is 27 cycles: 1 IDLE + 25 RUN + 1 DONE with `res_ready` held high.
- `win_ready` and `res_valid` are decoded from registered state only. They have no combinational path from `win_valid` or `res_ready`.
- Back-pressure: while in DONE with `res_ready` low, `res_data` is stable, `win_ready`=0, and upstream must hold `win_valid`/`win_data`.
- Reset asserted mid-RUN or mid-DONE: on the next edge the state returns to IDLE, the partial sum is discarded, `res_valid`=0 and the weights are cleared. No result is emitted for the aborted window.
- `win_valid` is not sampled outside IDLE.

## Structure
- Shared package `conv_pkg` holds:
  - constants `DW`, `K`, `ACC_W` and `TAPS` (= K*K);
  - the state enum (IDLE, RUN, DONE);
  - the tap-slice index function.
- Sub-module `mac_unit`:
  - registered signed DWxDW multiply-accumulate with a synchronous `clr` input and enable;
  - the FSM drives it with `clr` on acceptance and `en` during RUN.
- Top level contains the FSM, the window register, the weight register file and the tap/weight muxes.

## Test plan
- All weights 1, all pixels 1 -> `res_data`=25, with `res_valid` exactly 25 cycles after acceptance.
- Identity kernel (weight[12]=1, others 0) on a window whose center tap is -77 -> `res_data`=-77.
- All weights -256, all pixels -256 -> `res_data`=1638400. All weights -256, all pixels 255 -> `res_data`=-1632000.
- Hold `res_ready` low for 10 cycles while a second window waits:
  - `res_data` stays stable and `win_ready`=0 throughout;
  - after `res_ready` goes high, the second window is accepted at the next IDLE cycle.
- Weight writes that must be dropped:
  - write weight[0]=100 during RUN -> current and next results unchanged;
  - write to addr 27 in IDLE -> no weight changes.
- Reset during RUN, asserted 10 cycles into the window:
  - `res_valid` never rises for the aborted window;
  - a fresh all-ones window after reset gives `res_data`=0, because the weights were cleared.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and tap-slice helper for the 5x5 convolution MAC engine.
package conv_pkg;

   localparam int unsigned DW    = 9;
   localparam int unsigned K     = 5;
   localparam int unsigned TAPS  = K * K;
   localparam int unsigned ACC_W = 23;
   localparam int unsigned IDX_W = 5;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // LSB position of tap idx (= r*K+c) inside a packed window.
   function automatic int unsigned tap_lsb(input logic [IDX_W-1:0] idx);
      return 32'(idx) * DW;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed DWxDW multiply-accumulate with synchronous clear and enable.
module mac_unit
   import conv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [DW-1:0]    a_i,
   input  logic [DW-1:0]    b_i,
   output logic [ACC_W-1:0] sum_o
);

   logic signed [2*DW-1:0] prod;
   logic [ACC_W-1:0]       acc_q, acc_d;

   assign prod  = $signed(a_i) * $signed(b_i);
   // sum_o is the value the accumulator takes on this edge when enabled
   assign sum_o = acc_q + {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = sum_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/conv_window_mac.sv
// Sequential 5x5 convolution: latches one window, then accumulates one tap per cycle
// against a 25-entry weight register file and holds the sum behind a valid/ready handshake.
module conv_window_mac
   import conv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 win_valid,
   output logic                 win_ready,
   input  logic [TAPS*DW-1:0]   win_data,
   input  logic                 wgt_we,
   input  logic [IDX_W-1:0]     wgt_addr,
   input  logic [DW-1:0]        wgt_data,
   output logic                 busy,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ACC_W-1:0]     res_data
);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [TAPS*DW-1:0]  win_q, win_d;
   logic [DW-1:0]       wgt_q [TAPS];
   logic [DW-1:0]       wgt_d [TAPS];
   logic [ACC_W-1:0]    res_q, res_d;
   logic [ACC_W-1:0]    mac_sum;
   logic [DW-1:0]       tap_pix, tap_wgt;
   logic                accept, mac_en;

   assign tap_pix = win_q[tap_lsb(idx_q) +: DW];
   assign tap_wgt = wgt_q[idx_q];

   mac_unit u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr_i (accept),
      .en_i  (mac_en),
      .a_i   (tap_pix),
      .b_i   (tap_wgt),
      .sum_o (mac_sum)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      win_d   = win_q;
      wgt_d   = wgt_q;
      res_d   = res_q;
      accept  = 1'b0;
      mac_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Weights are only writable here, so they stay fixed across a window
            if (wgt_we && (wgt_addr < IDX_W'(TAPS))) begin
               wgt_d[wgt_addr] = wgt_data;
            end
            if (win_valid) begin
               accept  = 1'b1;
               win_d   = win_data;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            mac_en = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (idx_q == IDX_W'(TAPS - 1)) begin
               res_d   = mac_sum;
               state_d = StDone;
            end
         end
         StDone: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         win_q   <= '0;
         res_q   <= '0;
         for (int i = 0; i < TAPS; i++) begin
            wgt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         win_q   <= win_d;
         res_q   <= res_d;
         wgt_q   <= wgt_d;
      end
   end

   assign win_ready = (state_q == StIdle) && !rst;
   assign busy      = (state_q != StIdle);
   assign res_valid = (state_q == StDone);
   assign res_data  = res_q;

endmodule
